br_fifo_burst_reader: RTL
=========================

# br_fifo_burst_reader

Pop-side consumer for a br_fifo valid/ready pop interface. It drains single entries and packs BurstLen consecutive entries into one wide output beat with its own valid/ready handshake. An optional idle timeout flushes a partial burst. It sits directly downstream of a FIFO pop port, in front of wide-datapath consumers such as memory writers and packetizers.

## Interface
Parameters:
- Width, default 8: bits per FIFO entry; must be at least 1.
- BurstLen, default 4: entries per output beat; must be at least 2.
- TimeoutCycles, default 16: idle cycles before a partial flush; must be at least 1. Used only when the timeout feature is compiled in.
- CountWidth, localparam: $clog2(BurstLen+1).

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- pop_valid, input, 1: the FIFO has an entry.
- pop_ready, output, 1: this block accepts an entry.
- pop_data, input, Width: entry payload.
- out_valid, output, 1: a burst beat is available.
- out_ready, input, 1: the downstream consumer accepts the beat.
- out_data, output, Width*BurstLen: lane i occupies bits [i*Width +: Width]; lane 0 is the oldest entry.
- out_count, output, CountWidth: number of valid lanes, 1..BurstLen.
- busy, output, 1: partial data held or a beat is pending.

## Operation
State machine:
- COLLECT: the reset state.
  - pop_ready=1.
  - Each pop handshake (pop_valid&pop_ready) writes pop_data into lane[count] and increments count.
  - The handshake that makes count==BurstLen moves the block to HOLD.
- HOLD: out_valid=1, with out_count=count. The pop and output handshakes interact as follows:
  - pop_ready=out_ready.
  - Output handshake with no pop in the same cycle: go to COLLECT with count=0 and all lanes cleared.
  - Output handshake with a simultaneous pop: go to COLLECT with lane0=pop_data and count=1. This gives full throughput of one beat per BurstLen cycles.
  - No output handshake: no pop is possible, and out_data and out_count remain stable.

Data and status rules:
- Unused lanes (index ≥ out_count) read zero.
- busy = (count!=0) | out_valid.
- Handshake stability: upstream keeps pop_valid and pop_data stable under backpressure, and this block must keep out_valid and out_data stable while out_valid&!out_ready.
- No data loss or reorder: the concatenated lanes of the output beats equal the pop sequence exactly.

## Timing
- Reset:
  - While rst_n is low: pop_ready=0 (gated by reset), out_valid=0, out_data=0, out_count=0, busy=0, state COLLECT, count=0, idle counter=0.
  - First cycle after release: pop_ready=1.
- Latency: if the pop that completes a burst occurs in cycle t, out_valid is first high in cycle t+1. No combinational path exists from pop_valid to out_valid.
- out_ready→pop_ready is combinational in HOLD; it is the only input-to-output combinational path.
- Reset asserted mid-burst: all held data is discarded immediately (asynchronous), and outputs return to their reset values.

## Configuration
Macro: BR_FIFO_BURST_READER_TIMEOUT_EN.

Defined:
- An idle counter of width $clog2(TimeoutCycles+1) runs in COLLECT while count>0.
- It clears on every pop handshake and increments on every cycle with no pop.
- Timeout condition: counter==TimeoutCycles-1 and no pop. On that condition the next state is HOLD with out_count=count.
- Result: if the last pop occurs in cycle t, out_valid rises in cycle t+TimeoutCycles+1.
- A pop in the same cycle as the timeout condition wins: the counter clears and no flush occurs, unless that pop fills the burst.

Undefined:
- No idle counter is instantiated.
- Only full bursts are emitted, so out_count is always BurstLen.
- Partial data is held indefinitely until the burst fills.

## Test plan
- Width=8, BurstLen=4, out_ready=1:
  - Stimulus: push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Response: out_data=0x44332211 and out_count=4 one cycle after the last pop.
- Continuous stream of 0x01..0x08 with out_ready=1:
  - Response: two beats, 0x04030201 then 0x08070605, with pop_ready never low.
- Full burst held, out_ready=0 for 5 cycles:
  - Response: pop_ready=0, and out_data and out_count are stable all 5 cycles.
  - Then raise out_ready together with pop_valid carrying 0xAA: lane0=0xAA and count=1 on the next cycle.
- Timeout macro defined, TimeoutCycles=3:
  - Stimulus: pops 0x5A,0x6B, then idle.
  - Response: out_valid rises 4 cycles after the last pop, with out_count=2 and out_data=0x00006B5A.
  - Repeat with the macro undefined: out_valid never rises and busy stays 1.
- Reset mid-burst:
  - Stimulus: 2 entries held, then pulse rst_n low asynchronously.
  - Response: busy, out_valid, out_data and out_count go to 0 immediately.
  - After release, the next 4 pops form a clean burst without stale lanes.

Source files
------------

// File: rtl/br_fifo_burst_reader_if.sv
// rtl/br_fifo_burst_reader_if.sv - FIFO pop side and wide burst output bundle
interface br_fifo_burst_reader_if #(
    parameter int Width    = 8,
    parameter int BurstLen = 4
);
    localparam int CountWidth = $clog2(BurstLen + 1);

    logic                      pop_valid;
    logic                      pop_ready;
    logic [Width-1:0]          pop_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [Width*BurstLen-1:0] out_data;
    logic [CountWidth-1:0]     out_count;
    logic                      busy;

    modport master (
        input  pop_valid, pop_data, out_ready,
        output pop_ready, out_valid, out_data, out_count, busy
    );

    modport slave (
        output pop_valid, pop_data, out_ready,
        input  pop_ready, out_valid, out_data, out_count, busy
    );
endinterface

// File: rtl/br_fifo_burst_reader.sv
// rtl/br_fifo_burst_reader.sv - packs BurstLen FIFO entries into one wide beat
// Optional idle-timeout partial flush: BR_FIFO_BURST_READER_TIMEOUT_EN.
module br_fifo_burst_reader #(
    parameter int Width         = 8,
    parameter int BurstLen      = 4,
    parameter int TimeoutCycles = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    br_fifo_burst_reader_if.master  bus
);
    localparam int CountWidth = $clog2(BurstLen + 1);

    if (Width < 1 || BurstLen < 2 || TimeoutCycles < 1) begin : g_param_check
        $error("br_fifo_burst_reader: illegal parameter value");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic [Width-1:0]      lanes_q [BurstLen];
    logic [Width-1:0]      lanes_d [BurstLen];
    logic                  pop_hs;
    logic                  timeout_hit;

    assign pop_hs = bus.pop_valid & bus.pop_ready;

`ifdef BR_FIFO_BURST_READER_TIMEOUT_EN
    localparam int IdleWidth = $clog2(TimeoutCycles + 1);

    logic [IdleWidth-1:0] idle_q, idle_d;

    // The counter only matters while a partial burst sits in COLLECT.
    assign timeout_hit = (state_q == COLLECT) && (count_q != '0) && !pop_hs &&
                         (idle_q == IdleWidth'(TimeoutCycles - 1));

    always_comb begin
        idle_d = '0;
        if ((state_q == COLLECT) && (count_q != '0) && !pop_hs && !timeout_hit) begin
            idle_d = idle_q + IdleWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        bus.out_valid = (state_q == HOLD);
        // Reset gates ready so nothing is popped while the block is held in reset.
        bus.pop_ready = rst_n & ((state_q == COLLECT) | bus.out_ready);
        bus.out_count = count_q;
        bus.busy      = (count_q != '0) | (state_q == HOLD);
        bus.out_data  = '0;
        for (int i = 0; i < BurstLen; i++) begin
            bus.out_data[i*Width +: Width] = lanes_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lanes_d = lanes_q;
        case (state_q)
            COLLECT: begin
                if (pop_hs) begin
                    for (int i = 0; i < BurstLen; i++) begin
                        if (CountWidth'(i) == count_q) begin
                            lanes_d[i] = bus.pop_data;
                        end
                    end
                    count_d = count_q + CountWidth'(1);
                    if (count_q == CountWidth'(BurstLen - 1)) begin
                        state_d = HOLD;
                    end
                end else if (timeout_hit) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    // Clearing every lane keeps unused lanes of the next beat at zero.
                    for (int i = 0; i < BurstLen; i++) begin
                        lanes_d[i] = '0;
                    end
                    count_d = '0;
                    state_d = COLLECT;
                    if (bus.pop_valid) begin
                        lanes_d[0] = bus.pop_data;
                        count_d    = CountWidth'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            for (int i = 0; i < BurstLen; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lanes_q <= lanes_d;
        end
    end
endmodule
